// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MDU_EARLY_OUT_EN finishes trivial cases (divide by zero, signed overflow, zero multiply) in one cycle.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             Zero,
   output logic             Negative,
   output logic             Overflow,
   output logic             DivZero,
   output logic [1:0]       dbg_state
);
   // Handshakes: a transfer happens on a rising edge where valid && ready; flush cancels any transfer on that edge.
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);
`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2:0]         op_q;
   logic               neg_a_q, sign_diff_q, dz_q, ovf_q, early_q;
   logic [WIDTH-1:0]   operand_q;
   logic [2*WIDTH-1:0] acc;

   logic               signed_a, signed_b, neg_a, neg_b, is_div;
   logic               div_zero, div_ovf, mul_zero, early_hit;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] acc_init;

   always_comb begin
      is_div    = op[2];
      signed_a  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
      signed_b  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
      neg_a     = signed_a && a[WIDTH-1];
      neg_b     = signed_b && b[WIDTH-1];
      mag_a     = neg_a ? -a : a;
      mag_b     = neg_b ? -b : b;
      div_zero  = is_div && (b == '0);
      div_ovf   = is_div && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
      mul_zero  = !is_div && ((a == '0) || (b == '0));
      early_hit = EARLY_EN && (div_zero || div_ovf || mul_zero);
      // acc holds {high, low}: product for multiply, {remainder, dividend/quotient} for divide.
      acc_init  = is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
      // Early-out preloads the state a full divide-by-zero run would leave, so fix-up is shared.
      if (early_hit && div_zero)
         acc_init = {mag_a, {WIDTH{1'b1}}};
      else if (early_hit && mul_zero)
         acc_init = '0;
   end

   logic [WIDTH:0]     mul_sum, div_t;
   logic [WIDTH-1:0]   div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] acc_step;

   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand_q} : '0);
      div_t    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_ge   = div_t >= {1'b0, operand_q};
      div_diff = div_t[WIDTH-1:0] - operand_q;
      if (op_q[2])
         acc_step = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                           : {div_t[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         acc_step = {mul_sum, acc[WIDTH-1:1]};
   end

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quot, rem, fix_result;

   always_comb begin
      prod = sign_diff_q ? -acc : acc;
      quot = dz_q ? '1 : (sign_diff_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      rem  = neg_a_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      case (op_q)
         3'b000:                 fix_result = prod[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: fix_result = prod[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         fix_result = quot;
         default:                fix_result = rem;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign dbg_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         op_q        <= '0;
         neg_a_q     <= 1'b0;
         sign_diff_q <= 1'b0;
         dz_q        <= 1'b0;
         ovf_q       <= 1'b0;
         early_q     <= 1'b0;
         operand_q   <= '0;
         acc         <= '0;
         out_valid   <= 1'b0;
         result      <= '0;
         Zero        <= 1'b0;
         Negative    <= 1'b0;
         Overflow    <= 1'b0;
         DivZero     <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         Zero      <= 1'b0;
         Negative  <= 1'b0;
         Overflow  <= 1'b0;
         DivZero   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               op_q        <= op;
               neg_a_q     <= neg_a;
               sign_diff_q <= neg_a ^ neg_b;
               dz_q        <= div_zero;
               ovf_q       <= div_ovf;
               early_q     <= early_hit;
               operand_q   <= is_div ? mag_b : mag_a;
               acc         <= acc_init;
               cnt         <= '0;
               state       <= BUSY;
            end
            BUSY: if (early_q || cnt == LAST) begin
               result    <= fix_result;
               Zero      <= (fix_result == '0);
               Negative  <= fix_result[WIDTH-1];
               Overflow  <= ovf_q;
               DivZero   <= dz_q;
               out_valid <= 1'b1;
               state     <= DONE;
            end else begin
               acc <= acc_step;
               cnt <= cnt + CW'(1);
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               Zero      <= 1'b0;
               Negative  <= 1'b0;
               Overflow  <= 1'b0;
               DivZero   <= 1'b0;
               cnt       <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed RV32M cases, control scenarios and random operations
// checked against a 64-bit arithmetic reference model.
module tb_mul_div_unit;
   localparam int W = 32;

   logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [2:0]    op;
   logic [W-1:0]  a, b, result;
   logic          Zero, Negative, Overflow, DivZero;
   logic [1:0]    dbg_state;

   int checks   = 0;
   int failures = 0;

   mul_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .Zero(Zero), .Negative(Negative), .Overflow(Overflow),
      .DivZero(DivZero), .dbg_state(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: RISC-V M semantics via plain 64-bit / 32-bit arithmetic.
   task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output logic ovf, output logic dz,
                        output int lat);
      longint      sx, sy, ux, uy;
      logic [63:0] p;
      int          ix, iy;
      logic        ovf_case;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = longint'({32'b0, x});
      uy = longint'({32'b0, y});
      ix = $signed(x);
      iy = $signed(y);
      ovf_case = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      dz  = o[2] && (y == 0);
      ovf = (o == 3'b100 || o == 3'b110) && ovf_case;
      case (o)
         3'b000: begin p = ux * uy; res = p[31:0];  end
         3'b001: begin p = sx * sy; res = p[63:32]; end
         3'b010: begin p = sx * uy; res = p[63:32]; end
         3'b011: begin p = ux * uy; res = p[63:32]; end
         3'b100: res = (y == 0) ? 32'hFFFF_FFFF : ovf_case ? x : 32'(ix / iy);
         3'b101: res = (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'b110: res = (y == 0) ? x : ovf_case ? 32'h0 : 32'(ix % iy);
         default: res = (y == 0) ? x : x % y;
      endcase
      lat = W + 1;
`ifdef MDU_EARLY_OUT_EN
      if (dz || ovf || (!o[2] && (x == 0 || y == 0))) lat = 1;
`endif
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int hold);
      logic [31:0] er;
      logic        eo, ed, busy_ready, stable;
      int          el, lat;
      model(o, x, y, er, eo, ed, el);
      @(negedge clk);
      check("in_ready_idle", 64'(in_ready), 64'd1);
      op = o; a = x; b = y; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      busy_ready = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         busy_ready |= in_ready;
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 64'(lat), 64'(el));
      check("in_ready_busy", 64'(busy_ready | in_ready), 64'd0);
      check("result", 64'(result), 64'(er));
      check("flags", {60'd0, Zero, Negative, Overflow, DivZero},
            {60'd0, er == 0, er[31], eo, ed});
      if (hold > 0) begin
         stable = 1'b1;
         repeat (hold) begin
            @(posedge clk); #1;
            stable &= out_valid && (result == er) && (Zero == (er == 0)) && (DivZero == ed);
         end
         check("hold_stable", 64'(stable), 64'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("transfer", {62'd0, out_valid, in_ready}, 64'b01);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic seen;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = 3'b000; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {out_valid, in_ready, result, Zero, Negative, Overflow, DivZero, dbg_state},
            {1'b0, 1'b1, 32'h0, 4'b0, 2'b00});
      @(negedge clk); rst = 1'b0;

      run_op(3'b000, 32'd15, 32'd10, 0);
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'b100, -32'sd20, 32'd3, 0);
      run_op(3'b110, -32'sd20, 32'd3, 0);
      run_op(3'b101, 32'd50, 32'd30, 0);
      run_op(3'b111, 32'd50, 32'd30, 0);
      run_op(3'b101, 32'd100, 32'd0, 0);
      run_op(3'b110, 32'd100, 32'd0, 0);
      run_op(3'b100, -32'sd7, 32'd0, 0);
      run_op(3'b110, -32'sd7, 32'd0, 0);
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'b000, 32'd0, 32'd1234, 0);
      run_op(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5);

      // Flush after ten iterations of a multiply.
      @(negedge clk);
      op = 3'b000; a = 32'd15; b = 32'd10; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_idle", {62'd0, in_ready, out_valid}, 64'b10);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen |= out_valid;
      end
      check("flush_no_result", 64'(seen), 64'd0);

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      op = 3'b101; a = 32'd999; b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_reset", {out_valid, in_ready, result, Zero, Negative, Overflow, DivZero, dbg_state},
            {1'b0, 1'b1, 32'h0, 4'b0, 2'b00});
      @(negedge clk); rst = 1'b0;

      run_op(3'b100, 32'd1000, 32'd7, 0);

      for (int i = 0; i < 40; i++)
         run_op(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 2));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit, parametrised in data width, sitting in the Execute stage beside the single-cycle ALU. It accepts one operation per valid/ready transaction and computes it over WIDTH iterations (one bit per cycle). It returns a WIDTH-bit result with the same Zero/Negative/Overflow flag semantics as the ALU, plus a divide-by-zero flag. It supports a pipeline flush that aborts an operation in flight.

## Interface
- WIDTH, 32: operand/result width; legal values ≥ 4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; discards the in-flight operation.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  in  WIDTH  rs1 operand (dividend / multiplicand).
- b  in  WIDTH  rs2 operand (divisor / multiplier).
- out_valid  out  1  result available; held until taken.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- Zero  out  1  result == 0.
- Negative  out  1  result[WIDTH-1].
- Overflow  out  1  signed DIV/REM with a = MIN, b = -1.
- DivZero  out  1  DIV/DIVU/REM/REMU with b == 0.

## Operation
- States: IDLE, BUSY, DONE.
  - IDLE → BUSY on in_valid && in_ready.
  - BUSY → DONE after WIDTH iterations plus one fix-up cycle.
  - DONE → IDLE on out_valid && out_ready.
  - Any state → IDLE on flush.
- On accept, latch op, operand signs and operand magnitudes.
  - Signed interpretation: a for MULH/MULHSU/DIV/REM; b for MULH/DIV/REM.
- Multiply: shift-add over a 2·WIDTH accumulator. The fix-up cycle negates the product when the signs differ. MUL returns the low WIDTH bits; MULH* return the high WIDTH bits.
- Divide: restoring, one quotient bit per iteration. The fix-up cycle applies signs:
  - quotient is negated if the operand signs differ;
  - remainder takes the sign of the dividend.
- Special cases (RISC-V defined):
  - b == 0: quotient = all ones; remainder = a; DivZero = 1.
  - Signed a = 100…0, b = all ones: quotient = a; remainder = 0; Overflow = 1.
- Flags are registered alongside result and valid only while out_valid = 1. They are 0 for MUL*, except Zero and Negative.
- in_ready = (state == IDLE). The unit never accepts a new operation in DONE.
- flush has priority over all handshakes. A result being transferred on the same edge as flush is still discarded.

## Timing
- Reset values: state IDLE; in_ready = 1; out_valid = 0; result = 0; all flags 0; iteration counter 0.
- Reset asserted mid-operation returns the unit to IDLE immediately (asynchronously). No result is produced.
- Accept at edge E:
  - iterations occur on edges E+1 … E+WIDTH;
  - fix-up occurs on edge E+WIDTH+1;
  - out_valid is high from edge E+WIDTH+1.
  - Latency is WIDTH+1 cycles (33 for WIDTH = 32).
- result and flags stay stable while out_valid && !out_ready.
- Minimum issue interval: WIDTH+3 cycles (accept, WIDTH+1 compute, transfer, return to IDLE).
- Flush asserted on edge F returns the unit to IDLE after F; in_ready = 1 in the following cycle.

## Configuration
- MDU_EARLY_OUT_EN defined:
  - Divide-by-zero and signed-overflow divides skip iteration; BUSY → DONE on edge E+1, so out_valid is high after 1 cycle.
  - MUL* with a == 0 or b == 0 also finish at E+1 with result 0.
- MDU_EARLY_OUT_EN undefined: every operation takes the full WIDTH+1 cycles.
- Results and flags are bit-identical in both builds; only latency differs.

## Test plan
- MUL a = 15, b = 10 → result 150, Zero = 0; out_valid exactly 33 cycles after accept; in_ready low throughout.
- MULH a = 0xFFFFFFFF, b = 0xFFFFFFFF → 0x00000000, Zero = 1. MULHU with the same operands → 0xFFFFFFFE. MULHSU with the same operands → 0xFFFFFFFF, Negative = 1.
- DIV a = -20, b = 3 → 0xFFFFFFFA. REM with the same operands → 0xFFFFFFFE. DIVU a = 50, b = 30 → 1. REMU with the same operands → 20.
- DIVU a = 100, b = 0 → 0xFFFFFFFF with DivZero = 1. REM a = 100, b = 0 → 100. Latency is 1 cycle with MDU_EARLY_OUT_EN defined and 33 cycles without.
- DIV a = 0x80000000, b = 0xFFFFFFFF → 0x80000000, Overflow = 1, Negative = 1. REM with the same operands → 0, Zero = 1.
- Control checks:
  - Hold out_ready = 0 for 5 cycles in DONE → result stays stable, then one transfer.
  - flush at iteration 10 → IDLE next cycle, no out_valid.
  - rst asserted mid-BUSY → all outputs at reset values immediately.
